// File: rtl/priority_age_rr_arbiter_pkg.sv
// Purpose : shared types, default parameter values and helpers for the
//           priority/age/round-robin grant arbiter.
// Contents: lock_state_e - grant-lock state encoding
//           idx_width()  - index width for a requester count (min 1 bit)
package priority_age_rr_arbiter_pkg;

  localparam int DEF_INPUT_NUM        = 4;
  localparam int DEF_INPUT_PRIORITY_W = 4;
  localparam int DEF_AGE_W            = 4;
  localparam int DEF_AGE_THRESHOLD    = 8;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/priority_age_rr_arbiter_if.sv
// Purpose : request/grant bundle between the input-VC request logic and the
//           switch-allocator output stage.
// Signals : req_vld_i      per-input request valid
//           req_priority_i per-input priority, input i at [i*PRIORITY_W +: PRIORITY_W]
//           gnt_vld_o      a grant is offered this cycle
//           gnt_oh_o       one-hot granted input (0 when no grant)
//           gnt_idx_o      binary granted index (0 when no grant)
//           gnt_rdy_i      downstream accepts the offered grant
// Modports: master - requester/downstream side, slave - the arbiter
interface priority_age_rr_arbiter_if
  import priority_age_rr_arbiter_pkg::*;
#(
  parameter int INPUT_NUM        = DEF_INPUT_NUM,
  parameter int INPUT_NUM_IDX_W  = idx_width(INPUT_NUM),
  parameter int INPUT_PRIORITY_W = DEF_INPUT_PRIORITY_W
);

  logic [INPUT_NUM-1:0]                  req_vld_i;
  logic [INPUT_NUM*INPUT_PRIORITY_W-1:0] req_priority_i;
  logic                                  gnt_vld_o;
  logic [INPUT_NUM-1:0]                  gnt_oh_o;
  logic [INPUT_NUM_IDX_W-1:0]            gnt_idx_o;
  logic                                  gnt_rdy_i;

  modport master (
    output req_vld_i, req_priority_i, gnt_rdy_i,
    input  gnt_vld_o, gnt_oh_o, gnt_idx_o
  );

  modport slave (
    input  req_vld_i, req_priority_i, gnt_rdy_i,
    output gnt_vld_o, gnt_oh_o, gnt_idx_o
  );

endinterface

// File: rtl/priority_age_rr_arbiter_rr_mask_select.sv
// Purpose : round-robin pick - returns the first set candidate bit at or
//           after ptr_i, scanning upward with wrap-around.
// Ports   : cand_i    candidate vector
//           ptr_i     round-robin start position
//           sel_vld_o at least one candidate present
//           sel_oh_o  one-hot of the picked candidate
//           sel_idx_o binary index of the picked candidate
module priority_age_rr_arbiter_rr_mask_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     cand_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             sel_vld_o,
  output logic [N-1:0]     sel_oh_o,
  output logic [IDX_W-1:0] sel_idx_o
);

  // The candidates are duplicated side by side; masking off everything below
  // ptr_i in the lower copy lets a plain lowest-set-bit search wrap around.
  logic [2*N-1:0] dbl_cand;
  logic [2*N-1:0] dbl_mask;
  logic [2*N-1:0] dbl_masked;
  logic           found;

  always_comb begin
    dbl_cand   = {cand_i, cand_i};
    dbl_mask   = '0;
    for (int j = 0; j < 2*N; j++) begin
      dbl_mask[j] = (j >= int'(ptr_i));
    end
    dbl_masked = dbl_cand & dbl_mask;

    found     = 1'b0;
    sel_oh_o  = '0;
    sel_idx_o = '0;
    for (int j = 0; j < 2*N; j++) begin
      if (!found && dbl_masked[j]) begin
        found             = 1'b1;
        sel_oh_o[j % N]   = 1'b1;
        sel_idx_o         = IDX_W'(j % N);
      end
    end
    sel_vld_o = found;
  end

endmodule

// File: rtl/priority_age_rr_arbiter.sv
// Purpose : N-input grant arbiter for NoC router ports. Highest effective
//           priority wins, round-robin among equals, per-input age counters
//           promote starving requesters, and a granted-but-stalled input
//           keeps the grant until the downstream accepts it.
// Ports   : clk    clock
//           rst    synchronous reset, active-high
//           arb_if request/grant bundle (slave side), see the interface file
//
// Lock FSM
//   state     | meaning
//   LOCK_IDLE | no pending grant; arbitration is free
//   LOCK_HELD | grant offered to lock_idx_q was stalled; it is re-offered
module priority_age_rr_arbiter
  import priority_age_rr_arbiter_pkg::*;
#(
  parameter int INPUT_NUM        = DEF_INPUT_NUM,
  parameter int INPUT_NUM_IDX_W  = idx_width(INPUT_NUM),
  parameter int INPUT_PRIORITY_W = DEF_INPUT_PRIORITY_W,
  parameter int AGE_W            = DEF_AGE_W,
  parameter int AGE_THRESHOLD    = DEF_AGE_THRESHOLD
) (
  input  logic                        clk,
  input  logic                        rst,
  priority_age_rr_arbiter_if.slave    arb_if
);

  localparam int EFF_PRI_W = INPUT_PRIORITY_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_THRESHOLD);
  localparam logic [INPUT_NUM_IDX_W-1:0] LAST_IDX = INPUT_NUM_IDX_W'(INPUT_NUM - 1);

  lock_state_e                 lock_state_q, lock_state_d;
  logic [INPUT_NUM_IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic [INPUT_NUM_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [AGE_W-1:0]            age_q [INPUT_NUM];
  logic [AGE_W-1:0]            age_d [INPUT_NUM];

  logic [INPUT_NUM-1:0]        req_vld;
  logic [INPUT_NUM-1:0]        starve;
  logic [EFF_PRI_W-1:0]        eff [INPUT_NUM];
  logic [INPUT_NUM-1:0]        ge  [INPUT_NUM];
  logic [INPUT_NUM-1:0]        cand;

  logic                        sel_vld;
  logic [INPUT_NUM-1:0]        sel_oh;
  logic [INPUT_NUM_IDX_W-1:0]  sel_idx;

  logic                        lock_hold;
  logic                        gnt_vld;
  logic [INPUT_NUM-1:0]        gnt_oh;
  logic [INPUT_NUM_IDX_W-1:0]  gnt_idx;
  logic                        accept;
  logic                        stall;

  assign req_vld = arb_if.req_vld_i;

  // Starvation sits above the request priority, so among starving inputs the
  // request priority still orders them.
  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      starve[i] = (age_q[i] >= AGE_THR);
      eff[i]    = {starve[i], arb_if.req_priority_i[i*INPUT_PRIORITY_W +: INPUT_PRIORITY_W]};
    end
  end

  // ge[i][j]: input i is not beaten by input j (invalid j never beats anyone).
  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      ge[i] = '0;
      for (int j = 0; j < INPUT_NUM; j++) begin
        ge[i][j] = !req_vld[j] || (eff[i] >= eff[j]);
      end
      cand[i] = req_vld[i] && (&ge[i]);
    end
  end

  priority_age_rr_arbiter_rr_mask_select #(
    .N     (INPUT_NUM),
    .IDX_W (INPUT_NUM_IDX_W)
  ) u_rr_mask_select (
    .cand_i    (cand),
    .ptr_i     (rr_ptr_q),
    .sel_vld_o (sel_vld),
    .sel_oh_o  (sel_oh),
    .sel_idx_o (sel_idx)
  );

  // A lock only holds while its requester is still asking; a dropped request
  // falls back to normal arbitration in the same cycle.
  assign lock_hold = (lock_state_q == LOCK_HELD) && req_vld[lock_idx_q];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    if (!rst) begin
      if (lock_hold) begin
        gnt_vld             = 1'b1;
        gnt_idx             = lock_idx_q;
        gnt_oh[lock_idx_q]  = 1'b1;
      end else if (sel_vld) begin
        gnt_vld = 1'b1;
        gnt_idx = sel_idx;
        gnt_oh  = sel_oh;
      end
    end
  end

  assign accept = gnt_vld && arb_if.gnt_rdy_i;
  assign stall  = gnt_vld && !arb_if.gnt_rdy_i;

  assign arb_if.gnt_vld_o = gnt_vld;
  assign arb_if.gnt_oh_o  = gnt_oh;
  assign arb_if.gnt_idx_o = gnt_idx;

  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    case (lock_state_q)
      LOCK_IDLE: begin
        if (stall) begin
          lock_state_d = LOCK_HELD;
          lock_idx_d   = gnt_idx;
        end
      end
      LOCK_HELD: begin
        if (!lock_hold) begin
          // Locked requester vanished: the fallback grant may itself stall.
          lock_state_d = stall ? LOCK_HELD : LOCK_IDLE;
          lock_idx_d   = stall ? gnt_idx : lock_idx_q;
        end else if (accept) begin
          lock_state_d = LOCK_IDLE;
        end
      end
      default: lock_state_d = LOCK_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Ages keep counting during a stall, the locked input included.
  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (!req_vld[i]) begin
        age_d[i] = '0;
      end else if (accept && (gnt_idx == INPUT_NUM_IDX_W'(i))) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q <= LOCK_IDLE;
      lock_idx_q   <= '0;
      rr_ptr_q     <= '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int i = 0; i < INPUT_NUM; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_oh) && (!gnt_vld || gnt_oh[gnt_idx]));

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (rst)
    gnt_vld |-> (|req_vld));

  a_lock_req_held: assert property (@(posedge clk) disable iff (rst)
    (lock_state_q == LOCK_HELD) |-> req_vld[lock_idx_q]);

  a_lock_stable: assert property (@(posedge clk) disable iff (rst)
    lock_hold |-> (gnt_idx == lock_idx_q));

endmodule

// File: tb/tb_priority_age_rr_arbiter.sv
// Directed bench for the priority/age/round-robin arbiter. The stimulus
// thread pushes the hand-computed grant index for every cycle in which a
// grant is expected; the monitor pops on each offered grant at the falling
// edge and compares index and one-hot.
module tb_priority_age_rr_arbiter;

  localparam int N = 4;
  localparam int W = 2;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  priority_age_rr_arbiter_if #(
    .INPUT_NUM        (N),
    .INPUT_NUM_IDX_W  (W),
    .INPUT_PRIORITY_W (P)
  ) arb_if ();

  priority_age_rr_arbiter #(
    .INPUT_NUM        (N),
    .INPUT_NUM_IDX_W  (W),
    .INPUT_PRIORITY_W (P),
    .AGE_W            (4),
    .AGE_THRESHOLD    (8)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (arb_if)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // One cycle of stimulus; exp_idx < 0 means no grant is expected.
  task automatic step(input logic [N-1:0] vld, input logic [N*P-1:0] pri,
                      input logic rdy, input int exp_idx);
    arb_if.req_vld_i      = vld;
    arb_if.req_priority_i = pri;
    arb_if.gnt_rdy_i      = rdy;
    if (exp_idx >= 0) exp_q.push_back(exp_idx);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] vld, input logic [N*P-1:0] pri);
    rst                   = 1'b1;
    arb_if.req_vld_i      = vld;
    arb_if.req_priority_i = pri;
    arb_if.gnt_rdy_i      = 1'b1;
    #1;
    total++;
    if (arb_if.gnt_vld_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_gnt_vld got=%0b want=0", arb_if.gnt_vld_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    int            e;
    logic [N-1:0]  e_oh;
    forever begin
      @(negedge clk);
      if (arb_if.gnt_vld_o === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_grant got_idx=%0d want=no_grant", arb_if.gnt_idx_o);
        end else begin
          e    = exp_q.pop_front();
          e_oh = '0;
          e_oh[e] = 1'b1;
          if (int'(arb_if.gnt_idx_o) != e) begin
            bad++;
            $display("FAIL grant_idx got=%0d want=%0d", arb_if.gnt_idx_o, e);
          end
          total++;
          if (arb_if.gnt_oh_o !== e_oh) begin
            bad++;
            $display("FAIL grant_oh got=%b want=%b", arb_if.gnt_oh_o, e_oh);
          end
        end
      end else begin
        total++;
        if (arb_if.gnt_oh_o !== '0 || arb_if.gnt_idx_o !== '0) begin
          bad++;
          $display("FAIL idle_outputs got_oh=%b got_idx=%0d want=0/0",
                   arb_if.gnt_oh_o, arb_if.gnt_idx_o);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset with all requesting: no grant, then idx0 from rr_ptr=0.
    do_reset(4'b1111, '0);
    step(4'b1111, '0, 1'b1, 0);

    // Strict priority: pri idx0..3 = 3,9,2,8.
    do_reset(4'b1111, {4'd8, 4'd2, 4'd9, 4'd3});
    repeat (4) step(4'b1111, {4'd8, 4'd2, 4'd9, 4'd3}, 1'b1, 1);

    // Round-robin among equal priorities on inputs 0,1,3.
    do_reset(4'b1011, 16'h5555);
    step(4'b1011, 16'h5555, 1'b1, 0);
    step(4'b1011, 16'h5555, 1'b1, 1);
    step(4'b1011, 16'h5555, 1'b1, 3);
    step(4'b1011, 16'h5555, 1'b1, 0);
    step(4'b1011, 16'h5555, 1'b1, 1);
    step(4'b1011, 16'h5555, 1'b1, 3);

    // Lock: idx2 stalls, idx0 arrives with pri 15, idx2 keeps the grant.
    do_reset(4'b0000, '0);
    step(4'b0100, 16'h0400, 1'b0, 2);
    step(4'b0101, 16'h040F, 1'b0, 2);
    step(4'b0101, 16'h040F, 1'b0, 2);
    step(4'b0101, 16'h040F, 1'b1, 2);
    step(4'b0001, 16'h000F, 1'b1, 0);
    step(4'b0000, '0, 1'b1, -1);

    // Reset while locked on idx2: lock dropped, idx0 wins afterwards.
    step(4'b0100, 16'h0400, 1'b0, 2);
    do_reset(4'b0101, 16'h040F);
    step(4'b0101, 16'h040F, 1'b1, 0);

    // Starvation: idx3 (pri 1) wins on cycle 9, its age restarts, wins again on 18.
    do_reset(4'b1001, 16'h100F);
    for (int k = 1; k <= 18; k++) begin
      step(4'b1001, 16'h100F, 1'b1, (k == 9 || k == 18) ? 3 : 0);
    end

    // Two inputs starve together: higher request priority (idx1) first, then idx3.
    do_reset(4'b1011, 16'h102F);
    for (int k = 1; k <= 11; k++) begin
      step(4'b1011, 16'h102F, 1'b1, (k == 9) ? 1 : (k == 10) ? 3 : 0);
    end

    step(4'b0000, '0, 1'b1, -1);
    step(4'b0000, '0, 1'b1, -1);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_grants got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
